// File: rtl/bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bus_cycle_ctrl
// Brief    : 8086-style bus-cycle controller: region decode, chip selects,
//            per-region wait states and BUS_ERR flagging.
//            Optional ALE-to-strobe timeout: define BUS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bus_cycle_ctrl #(
    parameter logic        MEM_SPLIT = 1'b1,
    parameter logic [11:0] IO_BASE2  = 12'h000,
    parameter logic [11:0] IO_BASE3  = 12'h001,
    parameter int          WS0       = 0,
    parameter int          WS1       = 2,
    parameter int          WS2       = 1,
    parameter int          WS3       = 3,
    parameter int          TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ale,
    input  logic        i_m_io,
    input  logic [19:0] i_addr,
    input  logic        i_rd_n,
    input  logic        i_wr_n,
    output logic [3:0]  o_cs,
    output logic        o_ready,
    output logic        o_busy,
    output logic        o_bus_err
);

    localparam logic [3:0] c_ws0 = 4'(WS0);
    localparam logic [3:0] c_ws1 = 4'(WS1);
    localparam logic [3:0] c_ws2 = 4'(WS2);
    localparam logic [3:0] c_ws3 = 4'(WS3);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_WAIT    = 3'd2,
        S_DONE    = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t      r_state;
    logic [1:0]  r_region;
    logic [3:0]  r_wcnt;
    logic [3:0]  r_cs;
    logic        r_ready;
    logic        r_busy;
    logic        r_bus_err;

    state_t      w_state_nxt;
    logic [1:0]  w_region_nxt;
    logic [3:0]  w_wcnt_nxt;
    logic        w_err_nxt;
    logic        w_dec_vld;
    logic [1:0]  w_dec_region;
    logic [3:0]  w_dec_cs;
    logic [3:0]  w_ws_sel;
    logic        w_strobe_any;
    logic        w_strobe_both;
    logic        w_strobe_none;
    logic        w_unused;

`ifdef BUS_TIMEOUT_EN
    localparam logic [6:0] c_to_last = 7'(TIMEOUT - 1);
    logic [6:0] r_to_cnt;
    logic [6:0] w_to_nxt;
`endif

    // Only ADDR[19] and ADDR[15:4] take part in decoding.
    assign w_unused = ^{i_addr[18:16], i_addr[3:0]};

    // Region 2 is tested first so it wins when both IO bases are equal.
    always_comb begin
        w_dec_vld    = 1'b1;
        w_dec_region = 2'd0;
        if (i_m_io) begin
            w_dec_region = (i_addr[19] == MEM_SPLIT) ? 2'd1 : 2'd0;
        end else if (i_addr[15:4] == IO_BASE2) begin
            w_dec_region = 2'd2;
        end else if (i_addr[15:4] == IO_BASE3) begin
            w_dec_region = 2'd3;
        end else begin
            w_dec_vld    = 1'b0;
        end
    end

    assign w_dec_cs = w_dec_vld ? (4'b0001 << w_dec_region) : 4'b0000;

    always_comb begin
        case (r_region)
            2'd0:    w_ws_sel = c_ws0;
            2'd1:    w_ws_sel = c_ws1;
            2'd2:    w_ws_sel = c_ws2;
            default: w_ws_sel = c_ws3;
        endcase
    end

    assign w_strobe_any  = !i_rd_n || !i_wr_n;
    assign w_strobe_both = !i_rd_n && !i_wr_n;
    assign w_strobe_none = i_rd_n && i_wr_n;

    always_comb begin
        w_state_nxt  = r_state;
        w_region_nxt = r_region;
        w_wcnt_nxt   = r_wcnt;
        w_err_nxt    = 1'b0;
`ifdef BUS_TIMEOUT_EN
        w_to_nxt     = 7'd0;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_ale) begin
                    if (w_dec_vld) begin
                        w_region_nxt = w_dec_region;
                        w_state_nxt  = S_ADDR;
                    end else begin
                        w_err_nxt    = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (w_strobe_both) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_RECOVER;
                end else if (w_strobe_any) begin
                    w_wcnt_nxt  = w_ws_sel;
                    w_state_nxt = (w_ws_sel == 4'd0) ? S_DONE : S_WAIT;
                end else begin
`ifdef BUS_TIMEOUT_EN
                    if (r_to_cnt == c_to_last) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_RECOVER;
                    end else begin
                        w_to_nxt    = r_to_cnt + 7'd1;
                    end
`else
                    w_state_nxt = S_ADDR;
`endif
                end
            end
            S_WAIT: begin
                // Strobe release before the wait count expires is a protocol error.
                if (w_strobe_none) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_RECOVER;
                end else if (r_wcnt == 4'd1) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_wcnt_nxt  = r_wcnt - 4'd1;
                end
            end
            S_DONE: begin
                if (w_strobe_none) begin
                    w_state_nxt = S_RECOVER;
                end
            end
            S_RECOVER: begin
                w_wcnt_nxt  = 4'd0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they track the state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_region  <= 2'd0;
            r_wcnt    <= 4'd0;
            r_cs      <= 4'd0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_bus_err <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            r_to_cnt  <= 7'd0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_region  <= w_region_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_bus_err <= w_err_nxt;
            r_ready   <= (w_state_nxt != S_WAIT);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_cs      <= ((w_state_nxt == S_ADDR) || (w_state_nxt == S_WAIT) ||
                          (w_state_nxt == S_DONE)) ? (4'b0001 << w_region_nxt) : 4'b0000;
`ifdef BUS_TIMEOUT_EN
            r_to_cnt  <= w_to_nxt;
`endif
        end
    end

    // During the ALE cycle the decode bypasses the register so the device sees CS with ALE.
    assign o_cs      = ((r_state == S_IDLE) && i_ale) ? w_dec_cs : r_cs;
    assign o_ready   = r_ready;
    assign o_busy    = r_busy;
    assign o_bus_err = r_bus_err;

endmodule
`default_nettype wire
